// File: rtl/oled_paint_canvas_if.sv
// Pixel/mouse bundle between the canvas and its neighbours (Oled_Display, MouseCtl).
// The master drives requests and mouse data; the slave (canvas) returns pixel colour and status.
interface oled_paint_canvas_if;
   logic        frame_begin;
   logic [12:0] pixel_index;
   logic [11:0] xpos;
   logic [11:0] ypos;
   logic        left;
   logic        right;
   logic        new_event;
   logic        clear;
   logic [15:0] oled_data;
   logic        busy;
   logic [6:0]  cursor_col;
   logic [5:0]  cursor_row;

   modport master (
      output frame_begin, pixel_index, xpos, ypos, left, right, new_event, clear,
      input  oled_data, busy, cursor_col, cursor_row
   );

   modport slave (
      input  frame_begin, pixel_index, xpos, ypos, left, right, new_event, clear,
      output oled_data, busy, cursor_col, cursor_row
   );
endinterface

// File: rtl/oled_paint_canvas.sv
// Mouse-painted 1-bpp canvas with a frame-latched plus cursor, served to the OLED
// driver one registered RGB565 pixel per clock.
module oled_paint_canvas #(
   parameter int          WIDTH        = 96,
   parameter int          HEIGHT       = 64,
   parameter int          X_SHIFT      = 0,
   parameter int          Y_SHIFT      = 0,
   parameter int          BRUSH        = 1,
   parameter logic [15:0] COLOR_BG     = 16'h0000,
   parameter logic [15:0] COLOR_INK    = 16'h07E0,
   parameter logic [15:0] COLOR_CURSOR = 16'hF800
) (
   input logic               clk,
   input logic               reset,
   oled_paint_canvas_if.slave bus
);

   localparam int          NPIX       = WIDTH * HEIGHT;
   localparam int          NBRUSH     = BRUSH * BRUSH;
   localparam logic [12:0] LAST_ADDR  = 13'(NPIX - 1);
   localparam logic [4:0]  LAST_BRUSH = 5'(NBRUSH - 1);
   localparam logic [6:0]  MAX_COL    = 7'(WIDTH - 1);
   localparam logic [5:0]  MAX_ROW    = 6'(HEIGHT - 1);

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_IDLE  = 2'd1,
      ST_DRAW  = 2'd2
   } state_t;

   state_t      state_r;
   logic [12:0] clr_addr_r;
   logic [4:0]  brush_cnt_r;
   logic [6:0]  draw_col_r;
   logic [5:0]  draw_row_r;
   logic        ink_r;
   logic        busy_r;
   logic [6:0]  cursor_col_r;
   logic [5:0]  cursor_row_r;
   logic [15:0] oled_data_r;

   logic        canvas_mem [0:NPIX-1];

   logic [11:0] xs_s;
   logic [11:0] ys_s;
   logic [6:0]  live_col_s;
   logic [5:0]  live_row_s;
   logic [2:0]  bx_s;
   logic [2:0]  by_s;
   logic [7:0]  tgt_col_s;
   logic [6:0]  tgt_row_s;
   logic        cell_ok_s;
   logic [12:0] tgt_addr_s;
   logic        we_s;
   logic [12:0] waddr_s;
   logic        wdata_s;
   logic        pix_in_range_s;
   logic [6:0]  pix_col_s;
   logic [5:0]  pix_row_s;
   logic [12:0] rd_addr_s;
   logic        ink_bit_s;
   logic        cursor_hit_s;
   logic [15:0] pix_color_s;

   // True when a and b differ by at most one; operands stay below 127 so +1 never wraps.
   function automatic logic near1(input logic [6:0] a, input logic [6:0] b);
      near1 = (a == b) || (a == b + 7'd1) || (a + 7'd1 == b);
   endfunction

   // Mouse position scaled and clamped onto the canvas.
   always_comb begin
      xs_s = bus.xpos >> X_SHIFT;
      ys_s = bus.ypos >> Y_SHIFT;
      if (xs_s > 12'(WIDTH - 1)) begin
         live_col_s = MAX_COL;
      end else begin
         live_col_s = xs_s[6:0];
      end
      if (ys_s > 12'(HEIGHT - 1)) begin
         live_row_s = MAX_ROW;
      end else begin
         live_row_s = ys_s[5:0];
      end
   end

   // Current brush cell; cells beyond the right/bottom edge are skipped rather than wrapped.
   always_comb begin
      bx_s       = 3'(brush_cnt_r % 5'(BRUSH));
      by_s       = 3'(brush_cnt_r / 5'(BRUSH));
      tgt_col_s  = {1'b0, draw_col_r} + {5'b0, bx_s};
      tgt_row_s  = {1'b0, draw_row_r} + {4'b0, by_s};
      cell_ok_s  = (tgt_col_s <= 8'(WIDTH - 1)) && (tgt_row_s <= 7'(HEIGHT - 1));
      tgt_addr_s = 13'(tgt_row_s) * 13'(WIDTH) + 13'(tgt_col_s);
   end

   // Canvas write port request; a clear arriving mid-stroke suppresses the pending cell.
   always_comb begin
      we_s    = 1'b0;
      waddr_s = 13'd0;
      wdata_s = 1'b0;
      case (state_r)
         ST_CLEAR: begin
            we_s    = 1'b1;
            waddr_s = clr_addr_r;
            wdata_s = 1'b0;
         end
         ST_DRAW: begin
            if (cell_ok_s && !bus.clear) begin
               we_s    = 1'b1;
               waddr_s = tgt_addr_s;
               wdata_s = ink_r;
            end else begin
               we_s    = 1'b0;
            end
         end
         default: we_s = 1'b0;
      endcase
   end

   // Canvas storage is deliberately not reset; the CLEAR sweep initialises it.
   always_ff @(posedge clk) begin
      if (we_s) begin
         canvas_mem[waddr_s] <= wdata_s;
      end
   end

   // Control FSM: clear sweep, idle, brush stroke.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= ST_CLEAR;
         clr_addr_r  <= 13'd0;
         brush_cnt_r <= 5'd0;
         draw_col_r  <= 7'd0;
         draw_row_r  <= 6'd0;
         ink_r       <= 1'b0;
         busy_r      <= 1'b1;
      end else begin
         case (state_r)
            ST_CLEAR: begin
               if (bus.clear) begin
                  clr_addr_r <= 13'd0;
                  busy_r     <= 1'b1;
               end else if (clr_addr_r == LAST_ADDR) begin
                  state_r    <= ST_IDLE;
                  clr_addr_r <= 13'd0;
                  busy_r     <= 1'b0;
               end else begin
                  clr_addr_r <= clr_addr_r + 13'd1;
                  busy_r     <= 1'b1;
               end
            end
            ST_IDLE: begin
               if (bus.clear) begin
                  state_r    <= ST_CLEAR;
                  clr_addr_r <= 13'd0;
                  busy_r     <= 1'b1;
               end else if (bus.new_event && (bus.left || bus.right)) begin
                  state_r     <= ST_DRAW;
                  draw_col_r  <= live_col_s;
                  draw_row_r  <= live_row_s;
                  ink_r       <= bus.left;
                  brush_cnt_r <= 5'd0;
                  busy_r      <= 1'b1;
               end else begin
                  busy_r <= 1'b0;
               end
            end
            ST_DRAW: begin
               if (bus.clear) begin
                  state_r    <= ST_CLEAR;
                  clr_addr_r <= 13'd0;
                  busy_r     <= 1'b1;
               end else if (brush_cnt_r == LAST_BRUSH) begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
               end else begin
                  brush_cnt_r <= brush_cnt_r + 5'd1;
                  busy_r      <= 1'b1;
               end
            end
            default: begin
               state_r    <= ST_CLEAR;
               clr_addr_r <= 13'd0;
               busy_r     <= 1'b1;
            end
         endcase
      end
   end

   // Cursor only moves at frame start so a frame never shows two cursor positions.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cursor_col_r <= 7'd0;
         cursor_row_r <= 6'd0;
      end else if (bus.frame_begin) begin
         cursor_col_r <= live_col_s;
         cursor_row_r <= live_row_s;
      end else begin
         cursor_col_r <= cursor_col_r;
         cursor_row_r <= cursor_row_r;
      end
   end

   // Pixel colour lookup: cursor over ink over background.
   always_comb begin
      pix_in_range_s = (bus.pixel_index < 13'(NPIX));
      pix_col_s      = 7'(bus.pixel_index % 13'(WIDTH));
      pix_row_s      = 6'(bus.pixel_index / 13'(WIDTH));
      if (pix_in_range_s) begin
         rd_addr_s = bus.pixel_index;
      end else begin
         rd_addr_s = 13'd0;
      end
      ink_bit_s    = canvas_mem[rd_addr_s];
      cursor_hit_s = ((pix_col_s == cursor_col_r) && near1({1'b0, pix_row_s}, {1'b0, cursor_row_r})) ||
                     ((pix_row_s == cursor_row_r) && near1(pix_col_s, cursor_col_r));
      if (!pix_in_range_s) begin
         pix_color_s = COLOR_BG;
      end else if (cursor_hit_s) begin
         pix_color_s = COLOR_CURSOR;
      end else if ((state_r != ST_CLEAR) && ink_bit_s) begin
         pix_color_s = COLOR_INK;
      end else begin
         pix_color_s = COLOR_BG;
      end
   end

   // One-cycle registered read path.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         oled_data_r <= COLOR_BG;
      end else begin
         oled_data_r <= pix_color_s;
      end
   end

   assign bus.oled_data  = oled_data_r;
   assign bus.busy       = busy_r;
   assign bus.cursor_col = cursor_col_r;
   assign bus.cursor_row = cursor_row_r;

endmodule

// File: tb/tb_oled_paint_canvas.sv
// Self-checking bench for oled_paint_canvas: randomized strokes and reads checked
// against a plain array model of the canvas and cursor.
module tb_oled_paint_canvas;
   localparam int          W    = 96;
   localparam int          H    = 64;
   localparam int          B    = 2;
   localparam int          NPIX = W * H;
   localparam logic [15:0] BG   = 16'h0000;
   localparam logic [15:0] INK  = 16'h07E0;
   localparam logic [15:0] CUR  = 16'hF800;

   logic clk = 1'b0;
   logic reset;
   oled_paint_canvas_if bus ();

   oled_paint_canvas #(.BRUSH(B)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #80 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   bit canvas [NPIX];
   int m_cc = 0;
   int m_cr = 0;

   function automatic int live_col(input int x);
      return (x > W - 1) ? W - 1 : x;
   endfunction

   function automatic int live_row(input int y);
      return (y > H - 1) ? H - 1 : y;
   endfunction

   function automatic logic [15:0] exp_color(input int idx, input bit in_clear);
      int col, row, dc, dr;
      if (idx >= NPIX) return BG;
      col = idx % W;
      row = idx / W;
      dc  = (col > m_cc) ? col - m_cc : m_cc - col;
      dr  = (row > m_cr) ? row - m_cr : m_cr - row;
      if ((dc == 0 && dr <= 1) || (dr == 0 && dc <= 1)) return CUR;
      if (!in_clear && canvas[idx]) return INK;
      return BG;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_paint(input int x, input int y, input bit ink);
      int c0, r0;
      c0 = live_col(x);
      r0 = live_row(y);
      for (int dy = 0; dy < B; dy++)
         for (int dx = 0; dx < B; dx++)
            if (c0 + dx < W && r0 + dy < H) canvas[(r0 + dy) * W + c0 + dx] = ink;
   endtask

   task automatic model_wipe();
      for (int i = 0; i < NPIX; i++) canvas[i] = 1'b0;
   endtask

   task automatic wait_busy(output int cnt);
      cnt = 0;
      while (bus.busy === 1'b1 && cnt < 20000) begin
         cnt++;
         step();
      end
   endtask

   task automatic stroke(input int x, input int y, input bit l, input bit r, output int cnt);
      bus.xpos      = 12'(x);
      bus.ypos      = 12'(y);
      bus.left      = l;
      bus.right     = r;
      bus.new_event = 1'b1;
      step();
      bus.new_event = 1'b0;
      bus.left      = 1'b0;
      bus.right     = 1'b0;
      wait_busy(cnt);
      if (l || r) model_paint(x, y, l);
   endtask

   task automatic frame(input int x, input int y);
      bus.xpos        = 12'(x);
      bus.ypos        = 12'(y);
      bus.frame_begin = 1'b1;
      step();
      bus.frame_begin = 1'b0;
      m_cc = live_col(x);
      m_cr = live_row(y);
   endtask

   task automatic read_pixel(input int idx, output logic [15:0] got);
      bus.pixel_index = 13'(idx);
      step();
      got = bus.oled_data;
   endtask

   task automatic sweep(input string name);
      int bad;
      logic [15:0] exp;
      bad = 0;
      bus.pixel_index = 13'd0;
      for (int i = 0; i < NPIX; i++) begin
         step();
         exp = exp_color(i, 1'b0);
         n_checks++;
         if (bus.oled_data !== exp) begin
            n_fail++;
            if (bad < 8) $display("FAIL %s idx %0d: got %h expected %h", name, i, bus.oled_data, exp);
            bad++;
         end
         bus.pixel_index = 13'(i + 1);
      end
   endtask

   task automatic test_reset();
      int cnt;
      reset = 1'b1;
      repeat (3) step();
      n_checks += 4;
      if (bus.oled_data !== BG) begin n_fail++; $display("FAIL reset_oled: got %h expected %h", bus.oled_data, BG); end
      if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b expected 1", bus.busy); end
      if (bus.cursor_col !== 7'd0) begin n_fail++; $display("FAIL reset_col: got %0d expected 0", bus.cursor_col); end
      if (bus.cursor_row !== 6'd0) begin n_fail++; $display("FAIL reset_row: got %0d expected 0", bus.cursor_row); end
      reset = 1'b0;
      m_cc = 0;
      m_cr = 0;
      wait_busy(cnt);
      model_wipe();
      n_checks++;
      if (cnt != NPIX) begin n_fail++; $display("FAIL reset_clear_len: got %0d expected %0d", cnt, NPIX); end
      sweep("reset_sweep");
   endtask

   task automatic test_stroke();
      int cnt;
      int idx [7] = '{20*W+10, 20*W+11, 21*W+10, 21*W+11, 22*W+10, 20*W+12, 19*W+10};
      logic [15:0] got;
      stroke(10, 20, 1'b1, 1'b0, cnt);
      n_checks++;
      if (cnt != B * B) begin n_fail++; $display("FAIL stroke_busy: got %0d expected %0d", cnt, B * B); end
      foreach (idx[i]) begin
         read_pixel(idx[i], got);
         n_checks++;
         if (got !== exp_color(idx[i], 1'b0)) begin
            n_fail++; $display("FAIL stroke_pix %0d: got %h expected %h", idx[i], got, exp_color(idx[i], 1'b0));
         end
      end
   endtask

   task automatic test_clamp();
      int cnt;
      int idx [6] = '{NPIX-1, 0, W-1, (H-1)*W, NPIX-2, (H-2)*W+W-1};
      logic [15:0] got;
      frame(4000, 4000);
      n_checks += 2;
      if (bus.cursor_col !== 7'd95) begin n_fail++; $display("FAIL clamp_col: got %0d expected 95", bus.cursor_col); end
      if (bus.cursor_row !== 6'd63) begin n_fail++; $display("FAIL clamp_row: got %0d expected 63", bus.cursor_row); end
      stroke(4000, 4000, 1'b1, 1'b0, cnt);
      n_checks++;
      if (cnt != B * B) begin n_fail++; $display("FAIL clamp_busy: got %0d expected %0d", cnt, B * B); end
      frame(50, 30);
      foreach (idx[i]) begin
         read_pixel(idx[i], got);
         n_checks++;
         if (got !== exp_color(idx[i], 1'b0)) begin
            n_fail++; $display("FAIL clamp_pix %0d: got %h expected %h", idx[i], got, exp_color(idx[i], 1'b0));
         end
      end
   endtask

   task automatic test_erase();
      int cnt;
      logic [15:0] got;
      bit l [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      bit r [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      for (int k = 0; k < 4; k++) begin
         stroke(5, 5, l[k], r[k], cnt);
         n_checks++;
         if (cnt != ((l[k] || r[k]) ? B * B : 0)) begin
            n_fail++; $display("FAIL erase_busy step %0d: got %0d", k, cnt);
         end
         for (int j = 0; j < 3; j++) begin
            read_pixel(485 + j, got);
            n_checks++;
            if (got !== exp_color(485 + j, 1'b0)) begin
               n_fail++; $display("FAIL erase_pix step %0d idx %0d: got %h expected %h", k, 485 + j, got, exp_color(485 + j, 1'b0));
            end
         end
      end
   endtask

   task automatic test_cursor_latch();
      logic [15:0] got;
      int idx [6] = '{40*W, 40*W+1, 39*W, 41*W, 40*W-1, 41*W-1};
      bus.xpos = 12'd70;
      bus.ypos = 12'd10;
      repeat (5) step();
      n_checks += 2;
      if (bus.cursor_col !== 7'(m_cc)) begin n_fail++; $display("FAIL latch_hold_col: got %0d expected %0d", bus.cursor_col, m_cc); end
      if (bus.cursor_row !== 6'(m_cr)) begin n_fail++; $display("FAIL latch_hold_row: got %0d expected %0d", bus.cursor_row, m_cr); end
      frame(70, 10);
      n_checks += 2;
      if (bus.cursor_col !== 7'd70) begin n_fail++; $display("FAIL latch_new_col: got %0d expected 70", bus.cursor_col); end
      if (bus.cursor_row !== 6'd10) begin n_fail++; $display("FAIL latch_new_row: got %0d expected 10", bus.cursor_row); end
      frame(0, 40);
      foreach (idx[i]) begin
         read_pixel(idx[i], got);
         n_checks++;
         if (got !== exp_color(idx[i], 1'b0)) begin
            n_fail++; $display("FAIL cursor_edge %0d: got %h expected %h", idx[i], got, exp_color(idx[i], 1'b0));
         end
      end
   endtask

   task automatic test_drops();
      int cnt;
      logic [15:0] got;
      bus.xpos = 12'd30; bus.ypos = 12'd45; bus.left = 1'b1; bus.new_event = 1'b1;
      step();
      bus.xpos = 12'd60; bus.ypos = 12'd50;
      step();
      bus.new_event = 1'b0; bus.left = 1'b0;
      wait_busy(cnt);
      model_paint(30, 45, 1'b1);
      n_checks++;
      if (cnt != B * B - 1) begin n_fail++; $display("FAIL drop_busy: got %0d expected %0d", cnt, B * B - 1); end
      read_pixel(50 * W + 60, got);
      n_checks++;
      if (got !== exp_color(50 * W + 60, 1'b0)) begin n_fail++; $display("FAIL drop_pix: got %h expected %h", got, exp_color(50 * W + 60, 1'b0)); end
      read_pixel(46 * W + 31, got);
      n_checks++;
      if (got !== exp_color(46 * W + 31, 1'b0)) begin n_fail++; $display("FAIL drop_kept: got %h expected %h", got, exp_color(46 * W + 31, 1'b0)); end
   endtask

   task automatic test_clear();
      int cnt;
      logic [15:0] mid_exp;
      bus.xpos = 12'd80; bus.ypos = 12'd5; bus.left = 1'b1; bus.new_event = 1'b1;
      step();
      bus.new_event = 1'b0; bus.left = 1'b0;
      bus.clear = 1'b1;
      bus.pixel_index = 13'(NPIX - 1);
      mid_exp = exp_color(NPIX - 1, 1'b1);
      step();
      bus.clear = 1'b0;
      cnt = 0;
      while (bus.busy === 1'b1 && cnt < 20000) begin
         if (cnt == 5) begin
            n_checks++;
            if (bus.oled_data !== mid_exp) begin n_fail++; $display("FAIL clear_masks_ink: got %h expected %h", bus.oled_data, mid_exp); end
         end
         bus.new_event = (cnt == 100);
         bus.left      = (cnt == 100);
         cnt++;
         step();
      end
      bus.new_event = 1'b0; bus.left = 1'b0;
      model_wipe();
      n_checks++;
      if (cnt != NPIX) begin n_fail++; $display("FAIL clear_abort_len: got %0d expected %0d", cnt, NPIX); end
      sweep("clear_sweep");
      stroke(40, 20, 1'b1, 1'b0, cnt);
      bus.clear = 1'b1;
      step();
      bus.clear = 1'b0;
      repeat (1000) step();
      reset = 1'b1;
      step();
      n_checks++;
      if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL midclear_reset_busy: got %b expected 1", bus.busy); end
      reset = 1'b0;
      m_cc = 0;
      m_cr = 0;
      wait_busy(cnt);
      model_wipe();
      n_checks += 2;
      if (cnt != NPIX) begin n_fail++; $display("FAIL midclear_reset_len: got %0d expected %0d", cnt, NPIX); end
      if (bus.cursor_col !== 7'd0) begin n_fail++; $display("FAIL midclear_reset_col: got %0d expected 0", bus.cursor_col); end
   endtask

   task automatic test_random();
      int cnt, x, y, idx;
      bit l, r;
      logic [15:0] got;
      for (int k = 0; k < 30; k++) begin
         x = $urandom_range(0, 110);
         y = $urandom_range(0, 75);
         l = 1'($urandom_range(0, 1));
         r = 1'($urandom_range(0, 1));
         stroke(x, y, l, r, cnt);
         n_checks++;
         if (cnt != ((l || r) ? B * B : 0)) begin n_fail++; $display("FAIL rand_busy %0d: got %0d", k, cnt); end
         if ($urandom_range(0, 3) == 0) frame($urandom_range(0, 120), $urandom_range(0, 80));
      end
      for (int k = 0; k < 300; k++) begin
         idx = $urandom_range(0, 6400);
         read_pixel(idx, got);
         n_checks++;
         if (got !== exp_color(idx, 1'b0)) begin
            n_fail++; $display("FAIL rand_pix %0d: got %h expected %h", idx, got, exp_color(idx, 1'b0));
         end
      end
      sweep("rand_sweep");
   endtask

   initial begin
      reset           = 1'b1;
      bus.frame_begin = 1'b0;
      bus.pixel_index = 13'd0;
      bus.xpos        = 12'd0;
      bus.ypos        = 12'd0;
      bus.left        = 1'b0;
      bus.right       = 1'b0;
      bus.new_event   = 1'b0;
      bus.clear       = 1'b0;
      test_reset();
      test_stroke();
      test_clamp();
      test_erase();
      test_cursor_latch();
      test_drops();
      test_clear();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
